// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, in-order tracking of outstanding
// SRAM-like requests, and a decoupling instruction queue that drops stale responses after a redirect.
module inst_fetch_queue #(
   parameter logic [31:0] RESET_PC        = 32'h1c00_0000,
   parameter int          FIFO_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [3:0]  inst_sram_wstrb,
   output logic [31:0] inst_sram_wdata,
   output logic [31:0] inst_sram_addr,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        out_ex
);

   localparam int FAW = $clog2(FIFO_DEPTH);
   localparam int CW  = FAW + 1;
   localparam int TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [31:0]    fetch_pc;
   logic           adef_stall;
   logic [CW-1:0]  inflight;
   logic [CW-1:0]  inflight_next;
   logic [CW-1:0]  discard_cnt;

   logic [31:0]    tag_pc [MAX_OUTSTANDING];
   logic [TAW-1:0] tag_wr;
   logic [TAW-1:0] tag_rd;

   logic [31:0]    fifo_pc   [FIFO_DEPTH];
   logic [31:0]    fifo_inst [FIFO_DEPTH];
   logic           fifo_ex   [FIFO_DEPTH];
   logic [FAW-1:0] fifo_wr;
   logic [FAW-1:0] fifo_rd;
   logic [CW-1:0]  fifo_count;

   logic           aligned;
   logic           credit;
   logic           issue_ok;
   logic           accept;
   logic           resp;
   logic           resp_keep;
   logic           adef_push;
   logic           fifo_push;
   logic           fifo_pop;

   // Credit counts discarded requests too, so every outstanding response always has a FIFO slot.
   assign aligned   = (fetch_pc[1:0] == 2'b00);
   assign credit    = (inflight < CW'(MAX_OUTSTANDING)) &&
                      (({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH));
   assign issue_ok  = !redirect_valid && !adef_stall && credit;

   assign inst_sram_req   = rstn && issue_ok && aligned;
   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'b10;
   assign inst_sram_wstrb = 4'b0000;
   assign inst_sram_wdata = 32'h0;
   assign inst_sram_addr  = fetch_pc;

   assign accept    = inst_sram_req && inst_sram_addr_ok;
   assign resp      = inst_sram_data_ok && (inflight != '0);
   assign resp_keep = resp && (discard_cnt == '0);
   assign adef_push = rstn && issue_ok && !aligned && !resp_keep;
   assign fifo_push = resp_keep || adef_push;
   assign fifo_pop  = out_valid && out_ready;

   always_comb begin
      inflight_next = inflight;
      if (accept) inflight_next = inflight_next + CW'(1);
      if (resp)   inflight_next = inflight_next - CW'(1);
   end

   // Control state; a redirect flushes the queue but leaves the tag queue to drain stale responses.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         fetch_pc    <= RESET_PC;
         adef_stall  <= 1'b0;
         inflight    <= '0;
         discard_cnt <= '0;
         tag_wr      <= '0;
         tag_rd      <= '0;
         fifo_wr     <= '0;
         fifo_rd     <= '0;
         fifo_count  <= '0;
      end else begin
         inflight <= inflight_next;
         if (accept) tag_wr <= (tag_wr == TAW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr + TAW'(1);
         if (resp)   tag_rd <= (tag_rd == TAW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd + TAW'(1);
         if (redirect_valid) begin
            fetch_pc    <= redirect_pc;
            adef_stall  <= 1'b0;
            discard_cnt <= inflight_next;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            fifo_count  <= '0;
         end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (adef_push) adef_stall <= 1'b1;
            if (resp && discard_cnt != '0) discard_cnt <= discard_cnt - CW'(1);
            if (fifo_push) fifo_wr <= fifo_wr + FAW'(1);
            if (fifo_pop)  fifo_rd <= fifo_rd + FAW'(1);
            if (fifo_push && !fifo_pop)      fifo_count <= fifo_count + CW'(1);
            else if (!fifo_push && fifo_pop) fifo_count <= fifo_count - CW'(1);
         end
      end
   end

   // Storage arrays carry no reset; the pointers above define which entries are live.
   always_ff @(posedge clk) begin
      if (accept) tag_pc[tag_wr] <= fetch_pc;
      if (fifo_push && !redirect_valid) begin
         fifo_pc[fifo_wr]   <= resp_keep ? tag_pc[tag_rd] : fetch_pc;
         fifo_inst[fifo_wr] <= resp_keep ? inst_sram_rdata : 32'h0;
         fifo_ex[fifo_wr]   <= !resp_keep;
      end
   end

   assign out_valid = (fifo_count != '0);
   assign out_pc    = fifo_pc[fifo_rd];
   assign out_inst  = fifo_inst[fifo_rd];
   assign out_ex    = fifo_ex[fifo_rd];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Cycle-exact bench for inst_fetch_queue: a table of per-cycle vectors against a simple SRAM-like
// bus model (rdata = ~addr, one-cycle minimum latency), plus a hand-written backpressure sequence.
module tb_inst_fetch_queue;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok = 1'b0;
   logic [31:0] inst_sram_rdata = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_ex;

   logic        bus_accept = 1'b0;
   logic        resp_en = 1'b0;
   logic [31:0] pend[$];
   int          hs_count = 0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   inst_fetch_queue dut (
      .clk(clk), .rstn(rstn),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
      .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr(inst_sram_addr),
      .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata(inst_sram_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_inst(out_inst), .out_ex(out_ex)
   );

   assign inst_sram_addr_ok = bus_accept;

   // Bus model: responses come from entries accepted in earlier cycles, oldest first.
   always @(negedge clk) begin
      if (!rstn) begin
         pend.delete();
         inst_sram_data_ok = 1'b0;
      end else begin
         if (resp_en && pend.size() > 0) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = ~pend[0];
            void'(pend.pop_front());
         end else begin
            inst_sram_data_ok = 1'b0;
         end
         if (inst_sram_req && inst_sram_addr_ok) begin
            pend.push_back(inst_sram_addr);
            hs_count++;
         end
      end
   end

   typedef struct {
      logic        rn;
      logic        rd;
      logic [31:0] rpc;
      logic        rdy;
      logic        acc;
      logic        rsp;
      logic        e_req;
      logic [31:0] e_addr;
      int          e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic        e_ex;
      int          e_disc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rn, logic rd, logic [31:0] rpc, logic rdy, logic acc,
                               logic rsp, logic e_req, logic [31:0] e_addr, int e_valid,
                               logic [31:0] e_pc, logic [31:0] e_inst, logic e_ex, int e_disc);
      vec_t v;
      v.rn = rn; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.acc = acc; v.rsp = rsp;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_pc = e_pc; v.e_inst = e_inst; v.e_ex = e_ex; v.e_disc = e_disc;
      return v;
   endfunction

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      rstn           = v.rn;
      redirect_valid = v.rd;
      redirect_pc    = v.rpc;
      out_ready      = v.rdy;
      bus_accept     = v.acc;
      resp_en        = v.rsp;
   endtask

   task automatic check_output(input vec_t v, input int idx);
      check_val($sformatf("v%0d req", idx), 32'(inst_sram_req), 32'(v.e_req));
      if (v.e_req) check_val($sformatf("v%0d addr", idx), inst_sram_addr, v.e_addr);
      if (v.e_valid >= 0) check_val($sformatf("v%0d valid", idx), 32'(out_valid), 32'(v.e_valid));
      if (v.e_valid == 1) begin
         check_val($sformatf("v%0d pc", idx), out_pc, v.e_pc);
         check_val($sformatf("v%0d inst", idx), out_inst, v.e_inst);
         check_val($sformatf("v%0d ex", idx), 32'(out_ex), 32'(v.e_ex));
      end
      if (v.e_disc >= 0) check_val($sformatf("v%0d discard", idx), 32'(dut.discard_cnt), 32'(v.e_disc));
   endtask

   task automatic run_cycle(input vec_t v, input int idx);
      @(posedge clk);
      #2 apply_stimulus(v);
      #2 check_output(v, idx);
   endtask

   initial begin
      int hs_start;
      vec_t v;

      // Sequential streaming after reset
      vecs.push_back(mk(0,0,0,1,1,1, 0,0,-1,0,0,0,-1));
      vecs.push_back(mk(0,0,0,1,1,1, 0,0,0,0,0,0,-1));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h1c000000,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h1c000004,0,0,0,0,-1));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h1c000008,1,32'h1c000000,~32'h1c000000,0,-1));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h1c00000c,1,32'h1c000004,~32'h1c000004,0,-1));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h1c000010,1,32'h1c000008,~32'h1c000008,0,-1));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h1c000014,1,32'h1c00000c,~32'h1c00000c,0,-1));
      // Redirect with two requests outstanding, responses held back
      vecs.push_back(mk(0,0,0,1,1,0, 0,0,-1,0,0,0,-1));
      vecs.push_back(mk(0,0,0,1,1,0, 0,0,0,0,0,0,-1));
      vecs.push_back(mk(1,0,0,1,1,0, 1,32'h1c000000,0,0,0,0,-1));
      vecs.push_back(mk(1,0,0,1,1,0, 1,32'h1c000004,0,0,0,0,-1));
      vecs.push_back(mk(1,1,32'h1c000100,1,1,0, 0,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,1,1, 0,0,0,0,0,0,2));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h1c000100,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h1c000104,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h1c000108,1,32'h1c000100,~32'h1c000100,0,0));
      // Redirect in the same cycle as a data_ok, one other request outstanding
      vecs.push_back(mk(0,0,0,1,1,0, 0,0,-1,0,0,0,-1));
      vecs.push_back(mk(0,0,0,1,1,0, 0,0,0,0,0,0,-1));
      vecs.push_back(mk(1,0,0,1,1,0, 1,32'h1c000000,0,0,0,0,-1));
      vecs.push_back(mk(1,0,0,1,1,0, 1,32'h1c000004,0,0,0,0,-1));
      vecs.push_back(mk(1,1,32'h1c000100,1,1,1, 0,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h1c000100,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h1c000104,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h1c000108,1,32'h1c000100,~32'h1c000100,0,-1));
      // Misaligned redirect raises ADEF and stalls until the next redirect
      vecs.push_back(mk(0,0,0,0,1,1, 0,0,-1,0,0,0,-1));
      vecs.push_back(mk(0,0,0,0,1,1, 0,0,0,0,0,0,-1));
      vecs.push_back(mk(1,1,32'h1c000102,0,1,1, 0,0,0,0,0,0,-1));
      vecs.push_back(mk(1,0,0,0,1,1, 0,0,0,0,0,0,-1));
      vecs.push_back(mk(1,0,0,0,1,1, 0,0,1,32'h1c000102,32'h0,1,-1));
      vecs.push_back(mk(1,0,0,0,1,1, 0,0,1,32'h1c000102,32'h0,1,-1));
      vecs.push_back(mk(1,1,32'h1c000200,0,1,1, 0,0,1,32'h1c000102,32'h0,1,-1));
      vecs.push_back(mk(1,0,0,0,1,1, 1,32'h1c000200,0,0,0,0,-1));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h1c000204,0,0,0,0,-1));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h1c000208,1,32'h1c000200,~32'h1c000200,0,-1));
      // PC wraps from FFFFFFFC to 0
      vecs.push_back(mk(0,0,0,1,1,1, 0,0,-1,0,0,0,-1));
      vecs.push_back(mk(0,0,0,1,1,1, 0,0,0,0,0,0,-1));
      vecs.push_back(mk(1,1,32'hfffffffc,1,1,1, 0,0,0,0,0,0,-1));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'hfffffffc,0,0,0,0,-1));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h00000000,0,0,0,0,-1));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h00000004,1,32'hfffffffc,32'h00000003,0,-1));
      vecs.push_back(mk(1,0,0,1,1,1, 1,32'h00000008,1,32'h00000000,32'hffffffff,0,-1));

      for (int i = 0; i < vecs.size(); i++) run_cycle(vecs[i], i);

      // Backpressure: with out_ready low the queue fills after exactly FIFO_DEPTH handshakes
      v = mk(0,0,0,0,1,1, 0,0,-1,0,0,0,-1);
      run_cycle(v, 100);
      run_cycle(v, 101);
      hs_start = hs_count;
      v = mk(1,0,0,0,1,1, 0,0,-1,0,0,0,-1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #2 apply_stimulus(v);
      end
      #2;
      check_val("bp handshakes", 32'(hs_count - hs_start), 32'd4);
      check_val("bp req idle", 32'(inst_sram_req), 32'd0);
      check_val("bp head valid", 32'(out_valid), 32'd1);
      check_val("bp head pc", out_pc, 32'h1c000000);
      v = mk(1,0,0,1,1,1, 0,0,-1,0,0,0,-1);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #2 apply_stimulus(v);
         #2;
         check_val($sformatf("resume valid %0d", i), 32'(out_valid), 32'd1);
         check_val($sformatf("resume pc %0d", i), out_pc, 32'h1c000000 + 32'(4 * i));
         check_val($sformatf("resume inst %0d", i), out_inst, ~(32'h1c000000 + 32'(4 * i)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
